// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Also holds the helper that produces the RISC-V defined special-case results.
package mdu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Multiply-by-zero, divide-by-zero and signed overflow; op[1] splits REM* from DIV*.
    function automatic logic [XLEN-1:0] special_result(input mdu_op_e op,
                                                       input logic [XLEN-1:0] a,
                                                       input logic div_zero);
        if (!op[2]) return '0;
        if (div_zero) return op[1] ? a : '1;
        return op[1] ? '0 : DIV_OVF_DIVIDEND;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response interface of the mdu: operand/opcode request channel,
// valid/ready response channel, flush and busy status.
interface mdu_if #(
    parameter int XLEN = mdu_pkg::XLEN
) ();
    logic            i_flush;
    logic            i_req_valid;
    logic            o_req_ready;
    logic [2:0]      i_mdu_op;
    logic [XLEN-1:0] i_operand_a;
    logic [XLEN-1:0] i_operand_b;
    logic            o_rsp_valid;
    logic            i_rsp_ready;
    logic [XLEN-1:0] o_rsp_data;
    logic            o_busy;

    modport master (
        output i_flush, i_req_valid, i_mdu_op, i_operand_a, i_operand_b, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_busy
    );

    modport slave (
        input  i_flush, i_req_valid, i_mdu_op, i_operand_a, i_operand_b, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_busy
    );
endinterface

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module mdu_div_step #(
    parameter int XLEN = mdu_pkg::XLEN
) (
    input  logic [XLEN-1:0] rem,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);
    logic [XLEN:0] partial;

    assign partial  = {rem, dividend_bit};
    assign q_bit    = partial >= {1'b0, divisor};
    // When the subtraction happens the difference is below the divisor, so XLEN bits suffice.
    assign rem_next = q_bit ? XLEN'(partial - {1'b0, divisor}) : partial[XLEN-1:0];
endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit, one radix-2 step per cycle on magnitudes.
// Build option MDU_EARLY_OUT_EN: zero-operand multiplies and divide special cases go IDLE->DONE.
module mdu #(
    parameter int XLEN = mdu_pkg::XLEN
) (
    input logic  i_clk,
    input logic  i_reset,
    mdu_if.slave bus
);
    import mdu_pkg::*;

    // state | meaning
    // IDLE  | ready to accept a request
    // BUSY  | XLEN shift-add / shift-subtract steps
    // FIX   | sign correction, special cases, result select
    // DONE  | response held until the consumer takes it
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUSY = ST_BUSY;
    localparam logic [1:0] S_FIX  = ST_FIX;
    localparam logic [1:0] S_DONE = ST_DONE;
    localparam int CW = $clog2(XLEN) + 1;

    logic [1:0]        state;
    mdu_op_e           op_in, op_q;
    logic [XLEN-1:0]   a_mag, b_mag, a_q, opnd_q, acc_hi, acc_lo;
    logic [XLEN-1:0]   rsp_data, fix_result, quo, rem, rem_next;
    logic              a_neg, b_neg, div_zero, div_ovf, early_out;
    logic              neg_q, neg_rem_q, div_zero_q, div_ovf_q, q_bit;
    logic [CW-1:0]     step_cnt;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod;

    assign op_in    = mdu_op_e'(bus.i_mdu_op);
    assign a_neg    = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.i_operand_a[XLEN-1];
    assign b_neg    = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && bus.i_operand_b[XLEN-1];
    assign a_mag    = a_neg ? -bus.i_operand_a : bus.i_operand_a;
    assign b_mag    = b_neg ? -bus.i_operand_b : bus.i_operand_b;
    assign div_zero = op_in[2] && (bus.i_operand_b == '0);
    assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (bus.i_operand_a == DIV_OVF_DIVIDEND)
                      && (bus.i_operand_b == '1);

`ifdef MDU_EARLY_OUT_EN
    assign early_out = div_zero || div_ovf
                       || (!op_in[2] && (bus.i_operand_a == '0 || bus.i_operand_b == '0));
`else
    assign early_out = 1'b0;
`endif

    // Multiply shares acc_hi:acc_lo as the product; divide uses acc_hi as remainder
    // and acc_lo as dividend shifting out / quotient shifting in.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem          (acc_hi),
        .dividend_bit (acc_lo[XLEN-1]),
        .divisor      (opnd_q),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    assign prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign quo  = neg_q ? -acc_lo : acc_lo;
    assign rem  = neg_rem_q ? -acc_hi : acc_hi;

    always_comb begin
        fix_result = '0;
        case (op_q)
            OP_MUL:                        fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = quo;
            OP_REM, OP_REMU:               fix_result = rem;
            default:                       fix_result = '0;
        endcase
        if (div_zero_q || div_ovf_q) fix_result = special_result(op_q, a_q, div_zero_q);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            op_q       <= OP_MUL;
            a_q        <= '0;
            opnd_q     <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            step_cnt   <= '0;
            rsp_data   <= '0;
        end else if (bus.i_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (bus.i_req_valid) begin
                    op_q       <= op_in;
                    a_q        <= bus.i_operand_a;
                    neg_q      <= a_neg ^ b_neg;
                    neg_rem_q  <= a_neg;
                    div_zero_q <= div_zero;
                    div_ovf_q  <= div_ovf;
                    opnd_q     <= op_in[2] ? b_mag : a_mag;
                    acc_hi     <= '0;
                    acc_lo     <= op_in[2] ? a_mag : b_mag;
                    step_cnt   <= '0;
                    if (early_out) begin
                        rsp_data <= special_result(op_in, bus.i_operand_a, div_zero);
                        state    <= S_DONE;
                    end else begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (op_q[2]) begin
                        acc_hi <= rem_next;
                        acc_lo <= {acc_lo[XLEN-2:0], q_bit};
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                    step_cnt <= step_cnt + 1'b1;
                    if (step_cnt == CW'(XLEN - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    rsp_data <= fix_result;
                    state    <= S_DONE;
                end
                S_DONE: if (bus.i_rsp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_req_ready = (state == S_IDLE);
    assign bus.o_rsp_valid = (state == S_DONE);
    assign bus.o_busy      = (state != S_IDLE);
    assign bus.o_rsp_data  = rsp_data;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu (default build): directed RV32M vectors, randomized
// operations against a 64-bit arithmetic reference, backpressure, reset and flush aborts.
module tb_mdu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mdu_if #(.XLEN(32)) bus ();

    mdu dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic plus the RISC-V special-case rules.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_mdu_op    = op;
        bus.i_operand_a = a;
        bus.i_operand_b = b;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_req_valid = 1'b0;
    endtask

    // Called just after the accept edge; lat counts edges until o_rsp_valid is seen.
    task automatic wait_rsp(output int lat, output logic ready_seen);
        lat = 0;
        ready_seen = 1'b0;
        while (!bus.o_rsp_valid && lat < 100) begin
            if (bus.o_req_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        logic rdy;
        start_op(op, a, b);
        wait_rsp(lat, rdy);
        chk({tag, "_lat"}, 64'(lat), 64'd33);
        chk({tag, "_rdy"}, 64'(rdy), 64'd0);
        chk({tag, "_data"}, 64'(bus.o_rsp_data), 64'(exp));
        handshake();
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dv [16] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF},
        '{3'd5, 32'd7,          32'd2,          32'd3},
        '{3'd7, 32'd7,          32'd2,          32'd1},
        '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF},
        '{3'd6, 32'd5,          32'd0,          32'd5},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0},
        '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF},
        '{3'd7, 32'd5,          32'd0,          32'd5},
        '{3'd0, 32'd0,          32'h0001_2345, 32'd0},
        '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000}
    };

    function automatic logic [31:0] pick_operand();
        logic [31:0] edge_vals [4] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 255));
        return $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        int          lat;
        logic        rdy, valid_seen;

        bus.i_flush     = 1'b0;
        bus.i_req_valid = 1'b0;
        bus.i_mdu_op    = 3'd0;
        bus.i_operand_a = 32'd0;
        bus.i_operand_b = 32'd0;
        bus.i_rsp_ready = 1'b0;

        tick();
        tick();
        chk("rst_valid", 64'(bus.o_rsp_valid), 64'd0);
        chk("rst_busy",  64'(bus.o_busy),      64'd0);
        chk("rst_ready", 64'(bus.o_req_ready), 64'd1);
        chk("rst_data",  64'(bus.o_rsp_data),  64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++)
            run_op(dv[i].op, dv[i].a, dv[i].b, dv[i].exp, $sformatf("dir%0d", i));

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, ref_model(op, a, b), $sformatf("rnd%0d_op%0d", i, op));
        end

        // Backpressure: response held 10 cycles while a new request waits.
        exp = ref_model(3'd0, 32'h0001_2345, 32'h0000_0678);
        start_op(3'd0, 32'h0001_2345, 32'h0000_0678);
        wait_rsp(lat, rdy);
        chk("bp_lat", 64'(lat), 64'd33);
        bus.i_mdu_op    = 3'd5;
        bus.i_operand_a = 32'd1000;
        bus.i_operand_b = 32'd3;
        bus.i_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 64'(bus.o_rsp_valid), 64'd1);
            chk("bp_data",  64'(bus.o_rsp_data),  64'(exp));
        end
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        chk("bp_no_accept_at_hs", 64'(bus.o_busy), 64'd0);
        tick();
        bus.i_req_valid = 1'b0;
        chk("bp_accept_after_idle", 64'(bus.o_busy), 64'd1);
        wait_rsp(lat, rdy);
        chk("bp2_lat",  64'(lat), 64'd33);
        chk("bp2_data", 64'(bus.o_rsp_data), 64'd333);
        handshake();

        // Asynchronous reset in the middle of BUSY.
        start_op(3'd5, 32'hDEAD_BEEF, 32'd17);
        for (int i = 0; i < 10; i++) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.o_rsp_valid), 64'd0);
        chk("arst_busy",  64'(bus.o_busy),      64'd0);
        chk("arst_ready", 64'(bus.o_req_ready), 64'd1);
        chk("arst_data",  64'(bus.o_rsp_data),  64'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7, ref_model(3'd4, 32'hFFFF_FF9C, 32'd7), "post_rst");

        // Flush in BUSY: back to IDLE, response never appears.
        start_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 5; i++) tick();
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        chk("flush_busy",  64'(bus.o_busy),      64'd0);
        chk("flush_ready", 64'(bus.o_req_ready), 64'd1);
        valid_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_rsp_valid) valid_seen = 1'b1;
            tick();
        end
        chk("flush_no_valid", 64'(valid_seen), 64'd0);

        // Flush together with a request in IDLE: nothing is accepted.
        bus.i_flush     = 1'b1;
        bus.i_req_valid = 1'b1;
        tick();
        bus.i_flush     = 1'b0;
        bus.i_req_valid = 1'b0;
        chk("flush_req_no_accept", 64'(bus.o_busy), 64'd0);
        run_op(3'd7, 32'd1000, 32'd7, ref_model(3'd7, 32'd1000, 32'd7), "post_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
